spi_rx_packer: RTL and testbench

Downstream stage of the SPI slave receiver. Takes the slave's byte output and `done` strobe, which live in the `sclk` domain, and brings them into the system `clk` domain. Packs consecutive bytes MSB-first into words and buffers complete words in a small FIFO behind a valid/ready interface. Uses the chip-select to close frames: partial words are discarded and flagged.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_fifo.sv | 49 ++++
 rtl/spi_rx_packer.sv | 112 +++++++++++
 tb/tb_spi_rx_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI slave receive path and the master transmit path.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GRACE
  } rx_pack_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module spi_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: the storage array has no reset; only the pointers do, and the read mux hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr_q[AW-1:0]];
  end

endmodule

// File: rtl/spi_rx_packer.sv
// Brings SPI slave bytes into the clk domain, packs them MSB-first into words and
// queues complete words; chip-select release closes the frame after a grace window.
module spi_rx_packer
  import spi_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int GRACE_CYCLES   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [SPI_BYTE_W-1:0]                rx_byte,
  input  logic                                 rx_done,
  input  logic                                 cs,
  output logic [SPI_BYTE_W*BYTES_PER_WORD-1:0] word_data,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic                                 overflow,
  output logic                                 frame_err,
  input  logic                                 clr_flags
);

  localparam int W     = SPI_BYTE_W * BYTES_PER_WORD;
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int GW    = $clog2(GRACE_CYCLES + 1);

  rx_pack_state_t      state_q;
  logic [2:0]          done_sync_q;
  logic [1:0]          cs_sync_q;
  logic [GW-1:0]       grace_cnt_q;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [W-9:0]        shift_q, shift_d;
  logic                overflow_q, frame_err_q;

  logic                byte_stb, word_done, timeout, partial;
  logic                fifo_full, fifo_empty, push, pop;
  logic [W-1:0]        packed_word;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    byte_stb    = done_sync_q[1] && !done_sync_q[2];
    word_done   = byte_stb && (byte_cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    packed_word = {shift_q, rx_byte};
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    if (byte_stb) begin
      shift_d    = packed_word[W-9:0];
      byte_cnt_d = word_done ? '0 : byte_cnt_q + 1'b1;
    end
    // A byte landing on the timeout cycle is counted before deciding the frame was partial.
    timeout = (state_q == GRACE) && cs_sync_q[1] && (grace_cnt_q == '0);
    partial = timeout && (byte_cnt_d != '0);
    if (partial) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end
  end

  assign pop  = !fifo_empty && word_ready;
  assign push = word_done && (!fifo_full || pop);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_sync_q <= '0;
      cs_sync_q   <= '1;
      grace_cnt_q <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done_sync_q <= {done_sync_q[1:0], rx_done};
      cs_sync_q   <= {cs_sync_q[0], cs};
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      overflow_q  <= (word_done && fifo_full && !pop) || (overflow_q && !clr_flags);
      frame_err_q <= partial || (frame_err_q && !clr_flags);
      unique case (state_q)
        IDLE:   if (!cs_sync_q[1]) state_q <= ACTIVE;
        ACTIVE: if (cs_sync_q[1]) begin
                  state_q     <= GRACE;
                  grace_cnt_q <= GW'(GRACE_CYCLES - 1);
                end
        GRACE:  if (!cs_sync_q[1])            state_q     <= ACTIVE;
                else if (grace_cnt_q == '0)   state_q     <= IDLE;
                else                          grace_cnt_q <= grace_cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  spi_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (packed_word),
    .rdata (word_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_rx_packer.sv
// Directed bench for spi_rx_packer: bytes are driven as slow rx_done pulses and every
// delivered word is compared against a queue of expected words.
module tb_spi_rx_packer;

  localparam int BPW = 4;
  localparam int DEPTH = 4;
  localparam int G = 16;
  localparam int W = 8 * BPW;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_done = 1'b0;
  logic         cs = 1'b1;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         overflow;
  logic         frame_err;
  logic         clr_flags = 1'b0;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  spi_rx_packer #(
    .BYTES_PER_WORD (BPW),
    .FIFO_DEPTH     (DEPTH),
    .GRACE_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_done    (rx_done),
    .cs         (cs),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_flags  (clr_flags)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge, ahead of the rising edge that pops.
  always @(negedge clk) begin
    if (rst && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL extra_word: observed %h expected none", word_data);
      end else begin
        check("word", word_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // rx_done rises just after edge P0 and stays high four cycles; a word completing on
  // this byte is pushed at P3, so it is absent after P2 and present after P3.
  task automatic send_byte(input logic [7:0] b, input bit lat_chk = 1'b0, input bit ready_pulse = 1'b0);
    @(posedge clk); #1 rx_byte = b; rx_done = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    if (lat_chk) check("lat_before", W'(word_valid), W'(0));
    if (ready_pulse) word_ready = 1'b1;
    @(posedge clk); #1;
    if (lat_chk) check("lat_at3", W'(word_valid), W'(1));
    if (ready_pulse) word_ready = 1'b0;
    @(posedge clk); #1 rx_done = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_out,
                           input bit lat_chk = 1'b0, input bit ready_pulse = 1'b0);
    if (expect_out) exp_q.push_back(w);
    for (int i = 0; i < BPW; i++)
      send_byte(w[W-1-8*i -: 8], lat_chk && (i == BPW-1), ready_pulse && (i == BPW-1));
  endtask

  task automatic cs_low();
    @(posedge clk); #1 cs = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk); #1 cs = 1'b1;
    repeat (G + 6) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    word_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1 word_ready = 1'b0;
    check("drain_empty", W'(exp_q.size()), W'(0));
    check("valid_after_drain", W'(word_valid), W'(0));
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", W'(word_valid), W'(0));
    check("rst_data", word_data, W'(0));
    check("rst_ovf", W'(overflow), W'(0));
    check("rst_ferr", W'(frame_err), W'(0));
    rst = 1'b1;

    // Four bytes, one word
    cs_low();
    send_word(32'hDEADBEEF, 1'b1, 1'b1);
    check("t1_head", word_data, 32'hDEADBEEF);
    frame_end();
    check("t1_ferr", W'(frame_err), W'(0));
    drain();

    // Partial frame, then a clean frame
    cs_low();
    send_byte(8'h12);
    send_byte(8'h34);
    @(posedge clk); #1 cs = 1'b1;
    repeat (G + 2) @(posedge clk);
    #1 check("t2_ferr_early", W'(frame_err), W'(0));
    @(posedge clk); #1 check("t2_ferr_set", W'(frame_err), W'(1));
    check("t2_no_word", W'(word_valid), W'(0));
    pulse_clr();
    check("t2_ferr_clr", W'(frame_err), W'(0));
    cs_low();
    send_word(32'h01020304, 1'b1);
    frame_end();
    check("t2_ferr_after", W'(frame_err), W'(0));
    drain();

    // Last byte arrives after cs has risen
    cs_low();
    exp_q.push_back(32'hA1B2C3D4);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    @(posedge clk); #1 cs = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(8'hD4);
    repeat (G) @(posedge clk);
    #1;
    check("t3_ferr", W'(frame_err), W'(0));
    check("t3_valid", W'(word_valid), W'(1));
    drain();

    // Full FIFO with a pop coinciding with the fifth push
    pulse_clr();
    cs_low();
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 + 32'(i), 1'b1);
    check("t5_valid", W'(word_valid), W'(1));
    send_word(32'h1000_00FF, 1'b1, 1'b0, 1'b1);
    check("t5_no_ovf", W'(overflow), W'(0));
    frame_end();
    drain();

    // Overflow: fifth word is dropped
    cs_low();
    for (int i = 0; i < DEPTH; i++) send_word(32'h2000_0000 + 32'(i), 1'b1);
    send_word(32'h2000_00FF, 1'b0);
    check("t4_valid", W'(word_valid), W'(1));
    check("t4_ovf", W'(overflow), W'(1));
    frame_end();
    drain();
    check("t4_ovf_sticky", W'(overflow), W'(1));

    // Reset mid-frame with a buffered word and a set flag
    cs_low();
    send_word(32'h55AA55AA, 1'b0);
    send_byte(8'h99);
    send_byte(8'h88);
    @(posedge clk); #1 rst = 1'b0; cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_valid", W'(word_valid), W'(0));
    check("t6_data", word_data, W'(0));
    check("t6_ovf", W'(overflow), W'(0));
    check("t6_ferr", W'(frame_err), W'(0));
    rst = 1'b1;
    exp_q.delete();
    cs_low();
    send_word(32'hCAFEF00D, 1'b1);
    frame_end();
    check("t6_ferr_after", W'(frame_err), W'(0));
    drain();

    // clr_flags in the same cycle frame_err is set: set wins
    cs_low();
    send_byte(8'h77);
    @(posedge clk); #1 cs = 1'b1;
    repeat (G + 2) @(posedge clk);
    #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    check("t7_set_wins", W'(frame_err), W'(1));
    repeat (5) @(posedge clk);
    pulse_clr();
    check("t7_clr", W'(frame_err), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
